// File: rtl/sdram_burst_reader_pkg.sv
// Shared types and default constants for the SDRAM burst read master.
package sdram_burst_reader_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 30;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_BURST_WIDTH = 8;
    localparam int unsigned DEF_MAX_BURST   = 16;
    localparam int unsigned DEF_FIFO_DEPTH  = 64;
    localparam int unsigned DEF_COUNT_WIDTH = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Smaller of two unsigned values, used for burst length selection.
    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo_showahead.sv
// Show-ahead synchronous FIFO: head entry is visible on data_o whenever not empty.
module sync_fifo_showahead #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master: splits a (word address, count) command into
// MAX_BURST-aligned bursts, issuing each only once FIFO space is reserved for it.
module sdram_burst_reader
    import sdram_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int unsigned MAX_BURST   = DEF_MAX_BURST,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_address,
    input  logic [COUNT_WIDTH-1:0]  cmd_word_count,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic [BURST_WIDTH-1:0]  avm_burstcount,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    error
);

    localparam int unsigned LOG_MB = $clog2(MAX_BURST);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W  = FCNT_W + 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0]  total_q, total_d;
    logic [COUNT_WIDTH-1:0]  received_q, received_d;
    logic [OCC_W-1:0]        outstanding_q, outstanding_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    avm_read_q, avm_read_d;
    logic [ADDR_WIDTH-1:0]   avm_address_q, avm_address_d;
    logic [BURST_WIDTH-1:0]  avm_burstcount_q, avm_burstcount_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;

    logic                    cmd_hs, accept, rdv_ok, rdv_stray, pop, push_last, overflow;
    logic                    eval;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [COUNT_WIDTH-1:0]  rem_n;
    logic [BURST_WIDTH-1:0]  len_n;
    logic [OCC_W-1:0]        fifo_cnt_n, used_n;

    logic [DATA_WIDTH:0]     fifo_rdata;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    fifo_full, fifo_empty;

    assign cmd_hs    = (state_q == S_IDLE) & cmd_ready_q & cmd_valid;
    assign accept    = avm_read_q & ~avm_waitrequest;
    assign rdv_ok    = avm_readdatavalid & (outstanding_q != '0);
    assign rdv_stray = avm_readdatavalid & (outstanding_q == '0);
    assign pop       = out_ready & ~fifo_empty;
    assign push_last = ((received_q + COUNT_WIDTH'(1)) == total_q);
    assign overflow  = rdv_ok & fifo_full & ~pop;

    // Read-data buffer; every returned word already has a reserved slot.
    sync_fifo_showahead #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (rdv_ok),
        .data_i  ({push_last, avm_readdata}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: command capture, burst sizing, credit check and bookkeeping.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        total_d          = total_q;
        received_d       = received_q;
        avm_read_d       = 1'b0;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        error_d          = error_q;
        eval             = 1'b0;
        addr_n           = addr_q;
        rem_n            = remaining_q;
        len_n            = '0;

        // Credits held = words in FIFO + words still owed by the SDRAM.
        outstanding_d = outstanding_q + (accept ? OCC_W'(avm_burstcount_q) : '0) - OCC_W'(rdv_ok);
        fifo_cnt_n    = OCC_W'(fifo_count) + OCC_W'(rdv_ok & ~overflow) - OCC_W'(pop);
        used_n        = fifo_cnt_n + outstanding_d;

        if (rdv_ok) received_d = received_q + COUNT_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    addr_d      = cmd_address;
                    remaining_d = cmd_word_count;
                    total_d     = cmd_word_count;
                    received_d  = '0;
                    error_d     = 1'b0;
                    if (cmd_word_count != '0) begin
                        state_d = S_ISSUE;
                        addr_n  = cmd_address;
                        rem_n   = cmd_word_count;
                        eval    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (avm_read_q & avm_waitrequest) begin
                    avm_read_d = 1'b1;
                end else begin
                    if (accept) begin
                        addr_n      = addr_q + ADDR_WIDTH'(avm_burstcount_q);
                        rem_n       = remaining_q - COUNT_WIDTH'(avm_burstcount_q);
                        addr_d      = addr_n;
                        remaining_d = rem_n;
                    end
                    if (rem_n == '0) state_d = S_DRAIN;
                    else             eval    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Next burst stops at the MAX_BURST boundary and waits for enough credit.
        if (eval) begin
            len_n            = BURST_WIDTH'(min_u(32'(rem_n), MAX_BURST - 32'(addr_n[LOG_MB-1:0])));
            avm_address_d    = addr_n;
            avm_burstcount_d = len_n;
            avm_read_d       = (32'(used_n) + 32'(len_n)) <= FIFO_DEPTH;
        end

        error_d     = error_d | rdv_stray | overflow;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE) | (fifo_cnt_n != '0);
    end

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            remaining_q      <= '0;
            total_q          <= '0;
            received_q       <= '0;
            outstanding_q    <= '0;
            cmd_ready_q      <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
            error_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            total_q          <= total_d;
            received_q       <= received_d;
            outstanding_q    <= outstanding_d;
            cmd_ready_q      <= cmd_ready_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            error_q          <= error_d;
            busy_q           <= busy_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign avm_write      = 1'b0;
    assign avm_writedata  = '0;
    assign avm_byteenable = '1;
    assign out_valid      = ~fifo_empty;
    assign out_data       = fifo_rdata[DATA_WIDTH-1:0];
    assign out_last       = fifo_rdata[DATA_WIDTH] & ~fifo_empty;
    assign busy           = busy_q;
    assign error          = error_q;

endmodule
